// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg
// Shared constants for the coprocessor-0 unit:
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - exception codes written into Cause.ExcCode
//   - the processor-ID constant
//   - helpers that pack the SR and Cause fields into 32-bit words
package cp0_unit_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] PRID_VALUE = 32'h2021_0001;

  // SR layout: IM in [15:10], EXL in [1], IE in [0]
  function automatic logic [31:0] sr_word(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    return {16'b0, im, 8'b0, exl, ie};
  endfunction

  // Cause layout: BD in [31], IP in [15:10], ExcCode in [6:2]
  function automatic logic [31:0] cause_word(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    return {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// cp0_unit
// Coprocessor-0: status, cause, exception PC and processor ID registers
// plus the interrupt/exception request logic for a MIPS-style pipeline.
//
// Ports:
//   clk      in   1   clock, all state updates on the rising edge
//   reset    in   1   asynchronous active-high reset
//   A1       in   5   register number read onto DOut
//   A2       in   5   register number written by mtc0
//   Din      in  32   mtc0 write data
//   PC       in  32   PC of the victim instruction
//   ExcCode  in   5   pending exception code ([6:2]); 0 = none
//   HWInt    in   6   hardware interrupt lines
//   WE       in   1   mtc0 write enable
//   EXLClr   in   1   eret: clears SR.EXL
//   nBD      in   1   victim instruction sits in a branch delay slot
//   IntReq   out  1   take exception/interrupt request to the pipeline
//   EPC      out 30   EPC register ([31:2]), no write bypass
//   DOut     out 32   combinational read of register A1
module cp0_unit
  import cp0_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic [31:0] PC,
  input  logic [6:2]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic        nBD,
  output logic        IntReq,
  output logic [31:2] EPC,
  output logic [31:0] DOut
);

  // Architectural state
  logic [5:0]  im_reg, im_next;
  logic        exl_reg, exl_next;
  logic        ie_reg, ie_next;
  logic        bd_reg, bd_next;
  logic [5:0]  ip_reg, ip_next;
  logic [4:0]  exc_code_reg, exc_code_next;
  logic [31:2] epc_reg, epc_next;

  logic        int_int;
  logic        exc_req;
  logic [31:0] victim_pc;

  // Request logic. EXL masks both sources so a handler is not re-entered.
  assign int_int = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_req = (ExcCode != 5'd0) & ~exl_reg;
  assign IntReq  = (int_int | exc_req) & ~reset;

  // A delay-slot victim must restart at its branch, one word earlier.
  assign victim_pc = nBD ? (PC - 32'd4) : PC;

  always_comb begin
    im_next       = im_reg;
    exl_next      = exl_reg;
    ie_next       = ie_reg;
    bd_next       = bd_reg;
    exc_code_next = exc_code_reg;
    epc_next      = epc_reg;
    // Pending interrupt lines are sampled unconditionally.
    ip_next       = HWInt;

    if (IntReq) begin
      // Taking the exception wins over mtc0 and eret in the same cycle.
      exl_next      = 1'b1;
      bd_next       = nBD;
      exc_code_next = int_int ? EXC_INT : ExcCode;
      epc_next      = victim_pc[31:2];
    end else begin
      if (WE) begin
        case (A2)
          REG_SR: begin
            im_next  = Din[15:10];
            exl_next = Din[1];
            ie_next  = Din[0];
          end
          REG_EPC: epc_next = Din[31:2];
          default: ; // Cause and PRId are read-only
        endcase
      end
      // eret beats an SR write of the EXL bit in the same cycle.
      if (EXLClr) begin
        exl_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      im_reg       <= im_next;
      exl_reg      <= exl_next;
      ie_reg       <= ie_next;
      bd_reg       <= bd_next;
      ip_reg       <= ip_next;
      exc_code_reg <= exc_code_next;
      epc_reg      <= epc_next;
    end
  end

  assign EPC = epc_reg;

  // Read port shows registered state only, so a same-cycle write is not seen.
  always_comb begin
    case (A1)
      REG_SR:    DOut = sr_word(im_reg, exl_reg, ie_reg);
      REG_CAUSE: DOut = cause_word(bd_reg, ip_reg, exc_code_reg);
      REG_EPC:   DOut = {epc_reg, 2'b00};
      REG_PRID:  DOut = PRID_VALUE;
      default:   DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit
// Self-checking bench for cp0_unit. Expected values are pushed onto a
// scoreboard queue when stimulus is driven and popped when the DUT output
// is sampled (#1 after the rising edge, or #1 after a combinational change).
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic [31:0] pc;
  logic [6:2]  exc_code;
  logic [5:0]  hw_int;
  logic        we;
  logic        exl_clr;
  logic        n_bd;
  logic        int_req;
  logic [31:2] epc;
  logic [31:0] dout;

  cp0_unit dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (a1),
    .A2      (a2),
    .Din     (din),
    .PC      (pc),
    .ExcCode (exc_code),
    .HWInt   (hw_int),
    .WE      (we),
    .EXLClr  (exl_clr),
    .nBD     (n_bd),
    .IntReq  (int_req),
    .EPC     (epc),
    .DOut    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic push(input string name, input logic [31:0] value);
    exp_t x;
    x.name  = name;
    x.value = value;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; a1 = 5'd14; a2 = 5'd0; din = 32'd0; pc = 32'd0;
    exc_code = 5'd10; hw_int = 6'd0; we = 1'b0; exl_clr = 1'b0; n_bd = 1'b0;
    push("rst_dout_epc", 32'd0);
    push("rst_intreq", 32'd0);
    push("rst_epc_port", 32'd0);
    push("rst_sr", 32'd0);
    push("rst_cause", 32'd0);
    push("rst_prid", 32'h2021_0001);
    push("rst_unmapped", 32'd0);
    #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd15; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd7; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    tick();
    exc_code = 5'd0;
    reset = 1'b0;
    #1;
    $display("[TB] reset checks done");
  endtask

  task automatic test_exception();
    pc = 32'h0000_4180; exc_code = 5'd10; n_bd = 1'b0; a1 = 5'd14;
    push("exc_intreq_pre", 32'd1);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("exc_epc_read", 32'h0000_4180);
    push("exc_epc_port", 32'h0000_4180);
    push("exc_intreq_post", 32'd0);
    push("exc_sr", 32'h0000_0002);
    push("exc_cause", 32'h0000_0028);
    tick();
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    // asynchronous reset mid-handler
    reset = 1'b1;
    push("exc_reset_epc", 32'd0);
    push("exc_reset_cause", 32'd0);
    #1;
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    tick();
    exc_code = 5'd0;
    reset = 1'b0;
    #1;
    $display("[TB] exception pc=%h code=10 checked", pc);
  endtask

  task automatic test_interrupt();
    pc = 32'h0000_1000; we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
    push("int_sr_written", 32'h0000_0401);
    push("int_intreq_idle", 32'd0);
    tick();
    we = 1'b0; a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    // interrupt and exception together: interrupt code wins
    hw_int = 6'b000001; exc_code = 5'd12;
    push("int_intreq_pre", 32'd1);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("int_cause", 32'h0000_0400);
    push("int_sr", 32'h0000_0403);
    push("int_epc_port", 32'h0000_1000);
    tick();
    hw_int = 6'd0; exc_code = 5'd0;
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    $display("[TB] interrupt hw_int=1 checked");
  endtask

  task automatic test_delay_slot();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    pc = 32'h0000_3008; n_bd = 1'b1; exc_code = 5'd12;
    push("bd_intreq_pre", 32'd1);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("bd_epc_read", 32'h0000_3004);
    push("bd_cause", 32'h8000_0030);
    tick();
    n_bd = 1'b0; exc_code = 5'd0;
    a1 = 5'd14; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    $display("[TB] delay-slot exception pc=3008 checked");
  endtask

  task automatic test_exlclr();
    exc_code = 5'd4; pc = 32'h0000_5000;
    push("eclr_intreq_masked", 32'd0);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    exl_clr = 1'b1;
    push("eclr_sr", 32'h0000_0401);
    push("eclr_intreq_after", 32'd1);
    tick();
    exl_clr = 1'b0; a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("eclr_cause", 32'h0000_0010);
    push("eclr_epc_port", 32'h0000_5000);
    tick();
    exc_code = 5'd0; a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    $display("[TB] eret then AdEL exception checked");
  endtask

  task automatic test_write_suppress();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    we = 1'b1; a2 = 5'd14; din = 32'h1234_5677; exc_code = 5'd5;
    pc = 32'h0000_6000; n_bd = 1'b0; exl_clr = 1'b1;
    push("sup_intreq_pre", 32'd1);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("sup_epc_port", 32'h0000_6000);
    push("sup_epc_read", 32'h0000_6000);
    push("sup_sr", 32'h0000_0403);
    push("sup_cause", 32'h0000_0014);
    tick();
    we = 1'b0; exl_clr = 1'b0; exc_code = 5'd0;
    a1 = 5'd14; #1;
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    $display("[TB] write suppressed by exception checked");
  endtask

  task automatic test_mtc0_rw();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    we = 1'b1; a2 = 5'd14; din = 32'h1234_5677; a1 = 5'd14;
    push("rw_same_cycle_old", 32'h0000_6000);
    push("rw_port_no_bypass", 32'h0000_6000);
    #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("rw_epc_new", 32'h1234_5674);
    tick();
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    // read-only targets
    a2 = 5'd13; din = 32'hFFFF_FFFF;
    tick();
    a2 = 5'd15;
    tick();
    we = 1'b0;
    push("rw_cause_ro", 32'h0000_0014);
    push("rw_prid_ro", 32'h2021_0001);
    push("rw_epc_kept", 32'h1234_5674);
    a1 = 5'd13; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd15; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    a1 = 5'd14; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    // SR write with eret in the same cycle: EXL forced clear
    we = 1'b1; a2 = 5'd12; din = 32'h0000_FC03; exl_clr = 1'b1;
    push("rw_sr_exlclr", 32'h0000_FC01);
    tick();
    we = 1'b0; exl_clr = 1'b0; a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    we = 1'b1; din = 32'd0;
    push("rw_sr_zero", 32'd0);
    tick();
    we = 1'b0; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    $display("[TB] mtc0 read/write checks done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [5:0]  h;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      h = 6'($urandom_range(0, 63));
      we = 1'b1; a2 = 5'd14; din = d; hw_int = h;
      push("b2b_epc", {d[31:2], 2'b00});
      push("b2b_cause_ip", 32'h0000_0014 | ({26'd0, h} << 10));
      push("b2b_intreq", 32'd0);
      tick();
      a1 = 5'd14; #1;
      obs = dout; e = sb.pop_front(); tests_run++;
      if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
      a1 = 5'd13; #1;
      obs = dout; e = sb.pop_front(); tests_run++;
      if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
      obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
      if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
      $display("[TB] b2b %0d din=%h hw_int=%b", i, d, h);
    end
    we = 1'b0; hw_int = 6'd0;
  endtask

  task automatic test_reset_mid();
    exc_code = 5'd10; pc = 32'h0000_7000;
    push("mid_intreq_pre", 32'd1);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    reset = 1'b1;
    push("mid_intreq_rst", 32'd0);
    push("mid_epc_rst", 32'd0);
    #1;
    obs = {31'd0, int_req}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    obs = {epc, 2'b00}; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    push("mid_sr_after", 32'd0);
    tick();
    a1 = 5'd12; #1;
    obs = dout; e = sb.pop_front(); tests_run++;
    if (obs !== e.value) begin tests_failed++; $display("FAIL %s: observed %h required %h", e.name, obs, e.value); end
    exc_code = 5'd0; reset = 1'b0;
    $display("[TB] reset during pending exception checked");
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_delay_slot();
    test_exlclr();
    test_write_suppress();
    test_mtc0_rw();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
